sync_filter: RTL

Multi-channel clock-domain-crossing synchronizer with per-channel glitch filtering and optional edge-pulse outputs. Each of `WIDTH` asynchronous inputs passes through a `STAGES`-deep flop chain. It then passes through a stability filter that only accepts a new level after it has held for `FILTER_CYCLES` consecutive destination cycles. The block sits at the boundary of the `dest_clk` domain, replacing single-bit synchronizers on buttons, external status pins and slow cross-domain flags.

---
 rtl/sync_filter.sv | 91 +++++++++
 1 files changed

// File: rtl/sync_filter.sv
// Multi-channel synchronizer with per-channel stability filter and optional edge pulses.
// Define SYNC_FILTER_EDGE_EN to build the rise/fall registers; otherwise they are tied low.
module sync_filter #(
    parameter int unsigned          WIDTH         = 1,
    parameter int unsigned          STAGES        = 2,
    parameter int unsigned          FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0]     RESET_VALUE   = '0
) (
    input  logic             dest_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned CntW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_filter: STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("sync_filter: FILTER_CYCLES must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_filter: WIDTH must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        // Declaration initializers give the reset state at FPGA power-up.
        (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q = {STAGES{RESET_VALUE[i]}};
        logic [CntW-1:0] cnt_q  = '0;
        logic [CntW-1:0] cnt_d;
        logic            dout_q = RESET_VALUE[i];
        logic            dout_d;
        logic            s;

        assign s = sync_q[STAGES-1];

        always_comb begin
            cnt_d  = cnt_q;
            dout_d = dout_q;
            if (s == dout_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntMax) begin
                dout_d = s;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge dest_clk) begin
            if (!rst_n) begin
                sync_q <= {STAGES{RESET_VALUE[i]}};
                cnt_q  <= '0;
                dout_q <= RESET_VALUE[i];
            end else begin
                sync_q <= {sync_q[STAGES-2:0], din[i]};
                cnt_q  <= cnt_d;
                dout_q <= dout_d;
            end
        end

        assign dout[i] = dout_q;

`ifdef SYNC_FILTER_EDGE_EN
        logic rise_q = 1'b0;
        logic fall_q = 1'b0;

        // Pulses are registered on the same edge that moves dout, so they align with it.
        always_ff @(posedge dest_clk) begin
            if (!rst_n) begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= ~dout_q & dout_d;
                fall_q <= dout_q & ~dout_d;
            end
        end

        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
`else
        assign rise[i] = 1'b0;
        assign fall[i] = 1'b0;
`endif
    end

endmodule
